// File: rtl/decoder_fsm.sv
// Instruction decoder FSM (IDLE/DECODE/WRITE/HALT) driving register-file, ALU
// and I/O controls from registered outputs, so every control is glitch-free.
module decoder_fsm #(
  parameter  int REG_AW = 2,
  localparam int IR_W   = 4 + 3 * REG_AW,
  localparam int IMM_W  = 2 * REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IR_W-1:0]   ir,
  input  logic              ir_valid,
  output logic              ir_ready,
  input  logic              z_flag,
  input  logic              run,
  output logic              we,
  output logic [REG_AW-1:0] wa,
  output logic              rae,
  output logic [REG_AW-1:0] raa,
  output logic              rbe,
  output logic [REG_AW-1:0] rba,
  output logic              j_en,
  output logic              oe,
  output logic [1:0]        ie,
  output logic              ibuf_en,
  output logic [IMM_W-1:0]  imm,
  output logic              ze,
  output logic [3:0]        alu_op,
  output logic              halted
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_WRITE  = 2'd2,
    S_HALT   = 2'd3
  } state_t;

  // ir_ready must stay the MSB and halted the LSB: the constant vectors below rely on it.
  typedef struct packed {
    logic              ir_ready;
    logic              we;
    logic [REG_AW-1:0] wa;
    logic              rae;
    logic [REG_AW-1:0] raa;
    logic              rbe;
    logic [REG_AW-1:0] rba;
    logic              j_en;
    logic              oe;
    logic [1:0]        ie;
    logic              ibuf_en;
    logic [IMM_W-1:0]  imm;
    logic              ze;
    logic [3:0]        alu_op;
    logic              halted;
  } ctrl_t;

  localparam int    CTRL_W    = $bits(ctrl_t);
  localparam ctrl_t CTRL_IDLE = ctrl_t'({1'b1, {(CTRL_W-1){1'b0}}});
  localparam ctrl_t CTRL_HALT = ctrl_t'({{(CTRL_W-1){1'b0}}, 1'b1});

  state_t state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;
  logic   wr_q, wr_d;

  ctrl_t  dec_ctrl;
  logic   dec_wr;

  logic [3:0]        f_op;
  logic [REG_AW-1:0] f_fd;
  logic [REG_AW-1:0] f_fr;
  logic [REG_AW-1:0] f_fq;
  logic [IMM_W-1:0]  f_imm;

  assign f_op  = ir[IR_W-1 -: 4];
  assign f_fd  = ir[3*REG_AW-1 -: REG_AW];
  assign f_fr  = ir[2*REG_AW-1 -: REG_AW];
  assign f_fq  = ir[REG_AW-1:0];
  assign f_imm = ir[IMM_W-1:0];

  // Decode of the instruction currently on ir; only sampled on the acceptance edge.
  always_comb begin
    dec_ctrl        = '0;
    dec_ctrl.alu_op = 4'b1111;
    dec_ctrl.imm    = f_imm;
    dec_wr          = 1'b1;
    case (f_op)
      4'b0001: begin
        dec_ctrl.wa     = f_fr;
        dec_ctrl.raa    = f_fq;
        dec_ctrl.rae    = 1'b1;
        dec_ctrl.alu_op = 4'b1000;
      end
      4'b0010: begin
        dec_ctrl.wa = f_fq;
        dec_ctrl.ie = 2'b01;
      end
      4'b0011: begin
        dec_ctrl.raa    = f_fq;
        dec_ctrl.rae    = 1'b1;
        dec_ctrl.oe     = 1'b1;
        dec_ctrl.alu_op = 4'b1000;
        dec_wr          = 1'b0;
      end
      4'b0100: begin
        dec_ctrl.wa     = f_fr;
        dec_ctrl.raa    = f_fq;
        dec_ctrl.rae    = 1'b1;
        dec_ctrl.ze     = 1'b1;
        dec_ctrl.alu_op = 4'b0000;
      end
      4'b0101: begin
        dec_ctrl.j_en = 1'b1;
        dec_wr        = 1'b0;
      end
      4'b0110: begin
        dec_ctrl.j_en = ~z_flag;
        dec_wr        = 1'b0;
      end
      4'b0111: begin
        dec_ctrl.j_en = z_flag;
        dec_wr        = 1'b0;
      end
      4'b1000: begin
        dec_ctrl.raa    = f_fr;
        dec_ctrl.rba    = f_fq;
        dec_ctrl.rae    = 1'b1;
        dec_ctrl.rbe    = 1'b1;
        dec_ctrl.ze     = 1'b1;
        dec_ctrl.alu_op = 4'b0001;
        dec_wr          = 1'b0;
      end
      4'b1001, 4'b1010: begin
        dec_ctrl.wa      = f_fd;
        dec_ctrl.raa     = f_fd;
        dec_ctrl.rae     = 1'b1;
        dec_ctrl.ibuf_en = 1'b1;
        dec_ctrl.ze      = 1'b1;
        dec_ctrl.alu_op  = f_op[0] ? 4'b0010 : 4'b0011;
      end
      4'b1011, 4'b1100, 4'b1101, 4'b1110: begin
        dec_ctrl.wa     = f_fd;
        dec_ctrl.raa    = f_fr;
        dec_ctrl.rba    = f_fq;
        dec_ctrl.rae    = 1'b1;
        dec_ctrl.rbe    = 1'b1;
        dec_ctrl.ze     = 1'b1;
        dec_ctrl.alu_op = f_op - 4'd7;
      end
      4'b1111: begin
        dec_ctrl.wa = f_fd;
        dec_ctrl.ie = 2'b10;
      end
      default: begin
        dec_wr = 1'b0;
      end
    endcase
  end

  // DECODE and WRITE simply hold the controls captured at acceptance.
  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    wr_d    = wr_q;
    case (state_q)
      S_IDLE: begin
        if (ir_valid) begin
          if (f_op == 4'b0000) begin
            state_d = S_HALT;
            ctrl_d  = CTRL_HALT;
            wr_d    = 1'b0;
          end else begin
            state_d = S_DECODE;
            ctrl_d  = dec_ctrl;
            wr_d    = dec_wr;
          end
        end
      end
      S_DECODE: begin
        if (wr_q) begin
          state_d   = S_WRITE;
          ctrl_d.we = 1'b1;
        end else begin
          state_d = S_IDLE;
          ctrl_d  = CTRL_IDLE;
        end
      end
      S_WRITE: begin
        state_d = S_IDLE;
        ctrl_d  = CTRL_IDLE;
      end
      S_HALT: begin
        if (run) begin
          state_d = S_IDLE;
          ctrl_d  = CTRL_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        ctrl_d  = CTRL_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ctrl_q  <= CTRL_IDLE;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      wr_q    <= wr_d;
    end
  end

  assign ir_ready = ctrl_q.ir_ready;
  assign we       = ctrl_q.we;
  assign wa       = ctrl_q.wa;
  assign rae      = ctrl_q.rae;
  assign raa      = ctrl_q.raa;
  assign rbe      = ctrl_q.rbe;
  assign rba      = ctrl_q.rba;
  assign j_en     = ctrl_q.j_en;
  assign oe       = ctrl_q.oe;
  assign ie       = ctrl_q.ie;
  assign ibuf_en  = ctrl_q.ibuf_en;
  assign imm      = ctrl_q.imm;
  assign ze       = ctrl_q.ze;
  assign alu_op   = ctrl_q.alu_op;
  assign halted   = ctrl_q.halted;

endmodule

// File: doc/decoder_fsm.md
DECODER_FSM -- requirements
Module: decoder_fsm

Interface
REQ-001 Parameter REG_AW, default 2, register-address width; the register file has 2**REG_AW entries.
REQ-002 Parameter IR_W, fixed at 4+3*REG_AW (10 at default); it is not overridable.
REQ-003 Parameter IMM_W, fixed at 2*REG_AW (4 at default).
REQ-004 clk  in  1  system clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 ir  in  IR_W  instruction word.
REQ-007 ir_valid  in  1  ir is valid this cycle.
REQ-008 ir_ready  out  1  decoder can accept an instruction.
REQ-009 z_flag  in  1  ALU zero flag.
REQ-010 run  in  1  single-cycle pulse that releases the HALT state.
REQ-011 we / wa  out  1 / REG_AW  register write enable / write address.
REQ-012 rae, raa, rbe, rba  out  1, REG_AW, 1, REG_AW  read-port A/B enable and address.
REQ-013 j_en  out  1  jump strobe; imm carries the target.
REQ-014 oe  out  1  output-port enable.
REQ-015 ie  out  2  write-data source select: 00 ALU, 01 switch input, 10 immediate.
REQ-016 ibuf_en  out  1  immediate operand routed to ALU port B.
REQ-017 imm  out  IMM_W  immediate field.
REQ-018 ze  out  1  zero-flag update enable.
REQ-019 alu_op  out  4  ALU operation code.
REQ-020 halted  out  1  high while in HALT.

Function
REQ-021 The instruction fields SHALL be: op=ir[IR_W-1 -: 4], fd=ir[3*REG_AW-1 -: REG_AW], fr=ir[2*REG_AW-1 -: REG_AW], fq=ir[REG_AW-1:0], imm=ir[IMM_W-1:0].
REQ-022 The FSM SHALL have four states, IDLE, DECODE, WRITE and HALT, and SHALL hold the field values captured on the acceptance edge throughout DECODE and WRITE.
REQ-023 In IDLE, ir_ready SHALL be 1 and every other output SHALL be 0; ir_ready SHALL be 0 in all other states.
REQ-024 The decoder SHALL accept an instruction on a rising edge where ir_valid=1 and the state is IDLE; the next state SHALL be DECODE, or HALT when op=0000.
REQ-025 In DECODE, control outputs SHALL be driven per REQ-026 with we=0; next state SHALL be WRITE for write-type ops and IDLE otherwise.
REQ-026 Decode table (op: wa/raa/rba, enables, ie, alu_op; each row implies write-type unless marked no-write):
 - 0001 MOV: wa=fr, raa=fq, rae=1, ie=00, alu_op=1000.
 - 0010 IN: wa=fq, ie=01.
 - 0011 OUT (no-write): raa=fq, rae=1, oe=1, alu_op=1000.
 - 0100 NOT: wa=fr, raa=fq, rae=1, ze=1, alu_op=0000.
 - 0101 JMP (no-write): j_en=1.
 - 0110 JNZ (no-write): j_en=~z_flag.
 - 0111 JN (no-write): j_en=z_flag.
 - 1000 LT (no-write): raa=fr, rba=fq, rae=rbe=1, ze=1, alu_op=0001.
 - 1001 INC: wa=raa=fd, rae=1, ibuf_en=1, ze=1, alu_op=0010.
 - 1010 DEC: same as INC with alu_op=0011.
 - 1011/1100/1101/1110 ADD/SUB/AND/OR: wa=fd, raa=fr, rba=fq, rae=rbe=1, ze=1, alu_op=0100/0101/0110/0111.
 - 1111 MOVI: wa=fd, ie=10.
 - imm SHALL equal the captured imm for every op; all unlisted outputs SHALL be 0 and alu_op SHALL be 1111.
REQ-027 For JNZ/JN, z_flag SHALL be sampled on the acceptance edge and held; j_en SHALL be high for exactly one cycle.
REQ-028 In WRITE, the DECODE outputs SHALL be held, we SHALL be 1 for exactly one cycle, and next state SHALL be IDLE.
REQ-029 Latency: for acceptance at edge T, controls SHALL be valid in T..T+1 and we SHALL be high in T+1..T+2; minimum issue interval SHALL be 2 cycles for no-write ops and 3 cycles for write ops.
REQ-030 HALT SHALL drive all outputs 0 except halted=1, and SHALL ignore ir_valid.
REQ-031 A run pulse in HALT SHALL move the state to IDLE; run SHALL be ignored in other states.
REQ-032 Outputs SHALL never be X or Z.

Reset
REQ-033 While rst_n=0, the state SHALL be IDLE immediately, with all outputs 0 except ir_ready=1.
REQ-034 Reset asserted in DECODE, WRITE or HALT SHALL abort the operation, and we SHALL drop immediately.

Verification
REQ-035 ADD R1,R2,R3 (ir=1011_01_10_11), valid 1 cycle -> DECODE: wa=1, raa=2, rba=3, alu_op=0100, ze=1; next cycle we=1; then IDLE with ir_ready=1.
REQ-036 JNZ 0x5 with z_flag=0, then with z_flag=1 -> first case j_en=1 one cycle, imm=0101, no WRITE state; second case j_en=0.
REQ-037 HALT (ir=0) -> halted=1, ir_ready=0; ir_valid ignored for 10 cycles; run pulse -> IDLE.
REQ-038 MOVI R3,#0xA, then INC R0,#3 back-to-back with ir_valid held -> ie=10, wa=3, we=1; then ibuf_en=1, imm=0011, alu_op=0010; second instruction accepted only when ir_ready=1.
REQ-039 rst_n low during WRITE of SUB -> we=0 asynchronously, state IDLE, ir_ready=1 after release.
REQ-040 REG_AW=3 build, OR R7,R5,R6 (IR_W=13) -> wa=7, raa=5, rba=6, alu_op=0111.
